// File: rtl/inertial_ptch_src.sv
// Inertial pitch source: sequences SPI init/read of the IMU and fuses
// integrated pitch rate with an accel-derived correction into ptch.
module inertial_ptch_src #(
    parameter bit          fast_sim       = 1'b1,
    parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
    parameter logic [15:0] AZ_OFFSET      = 16'h00A0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] inert_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt,
    output logic        vld
);

    typedef enum logic [3:0] {
        INIT_WAIT, INIT1, INIT2, INIT3, INIT4,
        IDLE, RD_RL, RD_RH, RD_AL, RD_AH, UPDATE
    } state_t;

    localparam logic [15:0] TIMER_TC = fast_sim ? 16'd511 : 16'hFFFF;

    state_t             r_state;
    logic [15:0]        r_timer;
    logic               r_int_ff1;
    logic               r_int_ff2;
    logic               r_wrt;
    logic [15:0]        r_cmd;
    logic               r_vld;
    logic [26:0]        r_ptch_int;
    logic [15:0]        r_ptch_rt;
    logic [7:0]         r_rt_lo;
    logic [7:0]         r_rt_hi;
    logic [7:0]         r_az_lo;
    logic [7:0]         r_az_hi;

    logic [15:0]        w_rt_c;
    logic [15:0]        w_az_c;
    logic signed [25:0] w_az_ext;
    logic signed [25:0] w_prod;
    logic signed [15:0] w_acc;
    logic signed [15:0] w_ptch;
    logic [26:0]        w_fuse;
    logic [26:0]        w_ptch_int_nxt;
    logic               w_unused_hi;

    // Only the low byte of each SPI read carries data.
    assign w_unused_hi = ^inert_data[15:8];

    assign w_rt_c   = {r_rt_hi, r_rt_lo} - PTCH_RT_OFFSET;
    assign w_az_c   = {r_az_hi, r_az_lo} - AZ_OFFSET;
    assign w_az_ext = {{10{w_az_c[15]}}, w_az_c};
    assign w_prod   = w_az_ext * 26'sd327;
    assign w_acc    = {{3{w_prod[25]}}, w_prod[25:13]};
    assign w_ptch   = r_ptch_int[26:11];
    // Nudge the integrator toward the accel estimate by a fixed step.
    assign w_fuse   = (w_acc > w_ptch) ? 27'd1024 : (27'd0 - 27'd1024);
    assign w_ptch_int_nxt = r_ptch_int - {{11{w_rt_c[15]}}, w_rt_c} + w_fuse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_ff1 <= 1'b0;
            r_int_ff2 <= 1'b0;
        end else begin
            r_int_ff1 <= INT;
            r_int_ff2 <= r_int_ff1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT_WAIT;
            r_timer    <= '0;
            r_wrt      <= 1'b0;
            r_cmd      <= '0;
            r_vld      <= 1'b0;
            r_ptch_int <= '0;
            r_ptch_rt  <= '0;
            r_rt_lo    <= '0;
            r_rt_hi    <= '0;
            r_az_lo    <= '0;
            r_az_hi    <= '0;
        end else begin
            r_wrt <= 1'b0;
            r_vld <= 1'b0;
            case (r_state)
                INIT_WAIT: begin
                    if (r_timer == TIMER_TC) begin
                        r_timer <= '0;
                        r_state <= INIT1;
                        r_wrt   <= 1'b1;
                        r_cmd   <= 16'h0D02;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                INIT1: if (done) begin
                    r_state <= INIT2;
                    r_wrt   <= 1'b1;
                    r_cmd   <= 16'h1053;
                end
                INIT2: if (done) begin
                    r_state <= INIT3;
                    r_wrt   <= 1'b1;
                    r_cmd   <= 16'h1150;
                end
                INIT3: if (done) begin
                    r_state <= INIT4;
                    r_wrt   <= 1'b1;
                    r_cmd   <= 16'h1460;
                end
                INIT4: if (done) r_state <= IDLE;
                IDLE: if (r_int_ff2) begin
                    r_state <= RD_RL;
                    r_wrt   <= 1'b1;
                    r_cmd   <= 16'hA200;
                end
                RD_RL: if (done) begin
                    r_rt_lo <= inert_data[7:0];
                    r_state <= RD_RH;
                    r_wrt   <= 1'b1;
                    r_cmd   <= 16'hA300;
                end
                RD_RH: if (done) begin
                    r_rt_hi <= inert_data[7:0];
                    r_state <= RD_AL;
                    r_wrt   <= 1'b1;
                    r_cmd   <= 16'hAC00;
                end
                RD_AL: if (done) begin
                    r_az_lo <= inert_data[7:0];
                    r_state <= RD_AH;
                    r_wrt   <= 1'b1;
                    r_cmd   <= 16'hAD00;
                end
                RD_AH: if (done) begin
                    r_az_hi <= inert_data[7:0];
                    r_state <= UPDATE;
                end
                UPDATE: begin
                    r_ptch_int <= w_ptch_int_nxt;
                    r_ptch_rt  <= w_rt_c;
                    r_vld      <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= INIT_WAIT;
            endcase
        end
    end

    assign wrt     = r_wrt;
    assign cmd     = r_cmd;
    assign vld     = r_vld;
    assign ptch    = r_ptch_int[26:11];
    assign ptch_rt = r_ptch_rt;

endmodule

// File: tb/tb_inertial_ptch_src.sv
// Bench for inertial_ptch_src: SPI responder, scoreboard monitor on wrt/vld,
// directed init, read, reset-abort, stall and back-to-back scenarios.
module tb_inertial_ptch_src;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] inert_data = '0;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] ptch;
    logic [15:0] ptch_rt;
    logic        vld;

    inertial_ptch_src #(
        .fast_sim(1'b1),
        .PTCH_RT_OFFSET(16'h0050),
        .AZ_OFFSET(16'h00A0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .done(done),
        .inert_data(inert_data), .wrt(wrt), .cmd(cmd),
        .ptch(ptch), .ptch_rt(ptch_rt), .vld(vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] p;
        logic [15:0] r;
    } res_t;

    int          checks = 0;
    int          errors = 0;
    int          wrt_count = 0;
    logic [15:0] exp_cmd_q[$];
    res_t        exp_res_q[$];
    logic [15:0] rate_val = '0;
    logic [15:0] az_val = '0;
    bit          stall_init2 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] resp(input logic [15:0] c);
        case (c)
            16'hA200: resp = {8'hA5, rate_val[7:0]};
            16'hA300: resp = {8'h5A, rate_val[15:8]};
            16'hAC00: resp = {8'hC3, az_val[7:0]};
            16'hAD00: resp = {8'h3C, az_val[15:8]};
            default:  resp = 16'h0000;
        endcase
    endfunction

    // SPI slave model: done two clocks after each wrt, optionally stalled on 0x1053.
    initial begin
        int          pend;
        logic [15:0] pcmd;
        pend = 0;
        pcmd = '0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (wrt) begin
                pend = 1;
                pcmd = cmd;
            end else if (pend == 1 && !(stall_init2 && pcmd == 16'h1053)) begin
                done = 1'b1;
                inert_data = resp(pcmd);
                pend = 0;
            end
        end
    end

    // Monitor: pops expected commands on wrt and expected results on vld.
    initial begin
        int   reads;
        logic prev_vld;
        res_t e;
        reads = 0;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                reads = 0;
                prev_vld = 1'b0;
            end else begin
                if (wrt) begin
                    wrt_count++;
                    if (exp_cmd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_wrt: got cmd %h required no wrt", cmd);
                    end else begin
                        chk("cmd", {16'h0, cmd}, {16'h0, exp_cmd_q.pop_front()});
                    end
                    if (cmd[15]) reads++;
                end
                if (vld) begin
                    chk("vld_width", {31'h0, prev_vld}, 32'h0);
                    chk("reads_per_vld", reads, 4);
                    reads = 0;
                    if (exp_res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_vld: got ptch %h ptch_rt %h required no vld", ptch, ptch_rt);
                    end else begin
                        e = exp_res_q.pop_front();
                        chk("ptch", {16'h0, ptch}, {16'h0, e.p});
                        chk("ptch_rt", {16'h0, ptch_rt}, {16'h0, e.r});
                    end
                end
                prev_vld = vld;
            end
        end
    end

    task automatic wait_cmd(input logic [15:0] c, input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wrt === 1'b1 && cmd === c) && n < max);
        checks++;
        if (!(wrt === 1'b1 && cmd === c)) begin
            errors++;
            $display("FAIL wait_cmd_%h: timeout, got wrt=%b cmd=%h required wrt=1 cmd=%h", c, wrt, cmd, c);
        end
    endtask

    task automatic wait_vld(input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vld !== 1'b1 && n < max);
        checks++;
        if (vld !== 1'b1) begin
            errors++;
            $display("FAIL wait_vld: timeout, got vld=%b required 1", vld);
        end
    endtask

    task automatic wait_drained(input string name, input int max);
        int n;
        n = 0;
        while (exp_cmd_q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_cmd_q.size(), 0);
    endtask

    task automatic release_and_time_init(input string name);
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wrt !== 1'b1 && n < 600);
        chk(name, n, 512);
    endtask

    task automatic push_init();
        exp_cmd_q.push_back(16'h0D02);
        exp_cmd_q.push_back(16'h1053);
        exp_cmd_q.push_back(16'h1150);
        exp_cmd_q.push_back(16'h1460);
    endtask

    task automatic push_reads();
        exp_cmd_q.push_back(16'hA200);
        exp_cmd_q.push_back(16'hA300);
        exp_cmd_q.push_back(16'hAC00);
        exp_cmd_q.push_back(16'hAD00);
    endtask

    task automatic do_sample(input logic [15:0] rate, input logic [15:0] az,
                             input logic [15:0] ep, input logic [15:0] er);
        res_t e;
        rate_val = rate;
        az_val   = az;
        push_reads();
        e.p = ep;
        e.r = er;
        exp_res_q.push_back(e);
        INT = 1'b1;
        wait_cmd(16'hA200, 50);
        INT = 1'b0;
        wait_vld(200);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int   base;
        res_t e;

        // Reset state and init sequence timing
        repeat (3) @(negedge clk);
        chk("rst_wrt", {31'h0, wrt}, 32'h0);
        chk("rst_vld", {31'h0, vld}, 32'h0);
        chk("rst_cmd", {16'h0, cmd}, 32'h0);
        chk("rst_ptch", {16'h0, ptch}, 32'h0);
        chk("rst_ptch_rt", {16'h0, ptch_rt}, 32'h0);
        push_init();
        release_and_time_init("init_wait_len");
        wait_drained("init_done", 200);
        repeat (5) @(negedge clk);

        // Zero-offset sample: fuse pulls ptch_int to -1024
        do_sample(16'h0050, 16'h00A0, 16'hFFFF, 16'h0000);
        chk("vld_low_after", {31'h0, vld}, 32'h0);

        // Reset while in RD_AL aborts the read
        rate_val = 16'h0050;
        az_val   = 16'h00A0;
        exp_cmd_q.push_back(16'hA200);
        exp_cmd_q.push_back(16'hA300);
        exp_cmd_q.push_back(16'hAC00);
        INT = 1'b1;
        wait_cmd(16'hA200, 50);
        INT = 1'b0;
        wait_cmd(16'hAC00, 50);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_wrt", {31'h0, wrt}, 32'h0);
        chk("abort_vld", {31'h0, vld}, 32'h0);
        chk("abort_ptch", {16'h0, ptch}, 32'h0);
        chk("abort_cmd", {16'h0, cmd}, 32'h0);
        repeat (3) @(negedge clk);

        // Init replay with done withheld after the second init command
        push_init();
        stall_init2 = 1'b1;
        release_and_time_init("reinit_wait_len");
        wait_cmd(16'h1053, 100);
        @(negedge clk);
        base = wrt_count;
        repeat (40) @(negedge clk);
        chk("stall_no_wrt", wrt_count - base, 0);
        chk("stall_cmd", {16'h0, cmd}, 32'h1053);
        stall_init2 = 1'b0;
        wait_drained("reinit_done", 100);
        repeat (5) @(negedge clk);

        // Two rate samples from a fresh integrator: -3072 then -4096
        do_sample(16'h0850, 16'h00A0, 16'hFFFE, 16'h0800);
        do_sample(16'h0850, 16'h00A0, 16'hFFFE, 16'h0800);

        // INT held high across UPDATE: back-to-back reads, positive accel term
        rate_val = 16'h0050;
        az_val   = 16'h00A0;
        push_reads();
        push_reads();
        e.p = 16'hFFFE; e.r = 16'h0000; exp_res_q.push_back(e);
        e.p = 16'hFFFF; e.r = 16'hFFF0; exp_res_q.push_back(e);
        INT = 1'b1;
        wait_cmd(16'hA300, 100);
        INT = 1'b0;
        repeat (2) @(negedge clk);
        INT = 1'b1;
        wait_vld(200);
        rate_val = 16'h0040;
        az_val   = 16'h7FFF;
        @(negedge clk);
        chk("b2b_start", {15'h0, wrt, cmd}, {15'h0, 1'b1, 16'hA200});
        INT = 1'b0;
        wait_vld(200);
        repeat (4) @(negedge clk);

        // Negative accel term: acc=-7 is not above ptch=-1
        do_sample(16'h0050, 16'h0000, 16'hFFFE, 16'h0000);

        repeat (5) @(negedge clk);
        chk("cmd_q_drained", exp_cmd_q.size(), 0);
        chk("res_q_drained", exp_res_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
